// File: rtl/hsv_core_flush_pkg.sv
// Types and constants for the pipeline flush unit.
package hsv_core_flush_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2,
        ACK      = 2'd3
    } flush_state_t;

    localparam int FLUSH_STATS_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FLUSH_STATS_W-1:0] sat_inc(input logic [FLUSH_STATS_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/hsv_core_pkg.sv
// Core-wide shared types.
package hsv_core_pkg;

    typedef logic [31:0] word;

endpackage

// File: rtl/hsv_core_flush_unit_if.sv
// Flush request/ack handshake from the ctrlstatus FSM plus the fetch redirect channel.
interface hsv_core_flush_unit_if;
    import hsv_core_pkg::*;

    logic flush_req;
    word  flush_target;
    logic flush_ack;
    logic fetch_redirect_valid;
    word  fetch_redirect_pc;
    logic fetch_redirect_ready;

    // Environment side: the requesting FSM and the fetch unit.
    modport master (
        output flush_req,
        output flush_target,
        output fetch_redirect_ready,
        input  flush_ack,
        input  fetch_redirect_valid,
        input  fetch_redirect_pc
    );

    // Flush unit side.
    modport slave (
        input  flush_req,
        input  flush_target,
        input  fetch_redirect_ready,
        output flush_ack,
        output fetch_redirect_valid,
        output fetch_redirect_pc
    );

endinterface

// File: rtl/hsv_core_flush_drain_collector.sv
// Sticky per-stage drained mask; all_drained also folds in the current cycle's input.
module hsv_core_flush_drain_collector #(
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [NUM_STAGES-1:0] stage_drained,
    output logic                  all_drained
);

    logic [NUM_STAGES-1:0] mask_reg;
    logic [NUM_STAGES-1:0] merged;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mask_reg <= '0;
        end else begin
            mask_reg <= mask_reg | stage_drained;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_merge
            assign merged[gi] = mask_reg[gi] | stage_drained[gi];
        end
    endgenerate

    assign all_drained = &merged;

endmodule

// File: rtl/hsv_core_flush_unit.sv
// Pipeline flush sequencer: flush all stages, wait for drain, redirect fetch, ack the FSM.
// Optional statistics counters are enabled with HSV_CORE_FLUSH_STATS_EN.
module hsv_core_flush_unit
    import hsv_core_pkg::*;
    import hsv_core_flush_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic                     clk_core,
    input  logic                     rst_core,
    hsv_core_flush_unit_if.slave     flush_if,
    output logic [NUM_STAGES-1:0]    stage_flush,
    input  logic [NUM_STAGES-1:0]    stage_drained
`ifdef HSV_CORE_FLUSH_STATS_EN
    ,
    output logic [FLUSH_STATS_W-1:0] stat_flushes,
    output logic [FLUSH_STATS_W-1:0] stat_flush_cycles
`endif
);

    flush_state_t          state_reg, state_next;
    logic                  flush_ack_reg, flush_ack_next;
    logic [NUM_STAGES-1:0] stage_flush_reg, stage_flush_next;
    logic                  redirect_valid_reg, redirect_valid_next;
    word                   redirect_pc_reg, redirect_pc_next;
    logic                  all_drained;
    logic                  start_flush;

    assign start_flush = (state_reg == IDLE) && flush_if.flush_req;

    // Mask is cleared on the IDLE->DRAIN edge, so drained levels seen while idle never count.
    hsv_core_flush_drain_collector #(
        .NUM_STAGES (NUM_STAGES)
    ) u_drain_collector (
        .clk           (clk_core),
        .rst           (rst_core),
        .clear         (start_flush),
        .stage_drained (stage_drained),
        .all_drained   (all_drained)
    );

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_reg          <= IDLE;
            flush_ack_reg      <= 1'b0;
            stage_flush_reg    <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            state_reg          <= state_next;
            flush_ack_reg      <= flush_ack_next;
            stage_flush_reg    <= stage_flush_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        flush_ack_next      = flush_ack_reg;
        stage_flush_next    = stage_flush_reg;
        redirect_valid_next = redirect_valid_reg;
        redirect_pc_next    = redirect_pc_reg;

        unique case (state_reg)
            IDLE: begin
                if (flush_if.flush_req) begin
                    state_next       = DRAIN;
                    stage_flush_next = {NUM_STAGES{1'b1}};
                end
            end
            DRAIN: begin
                // Target is only stable once DRAIN has run, so it is sampled on exit.
                if (all_drained) begin
                    state_next          = REDIRECT;
                    redirect_pc_next    = flush_if.flush_target;
                    redirect_valid_next = 1'b1;
                end
            end
            REDIRECT: begin
                if (flush_if.fetch_redirect_ready) begin
                    state_next          = ACK;
                    redirect_valid_next = 1'b0;
                    flush_ack_next      = 1'b1;
                end
            end
            ACK: begin
                if (!flush_if.flush_req) begin
                    state_next       = IDLE;
                    flush_ack_next   = 1'b0;
                    stage_flush_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign flush_if.flush_ack            = flush_ack_reg;
    assign flush_if.fetch_redirect_valid = redirect_valid_reg;
    assign flush_if.fetch_redirect_pc    = redirect_pc_reg;
    assign stage_flush                   = stage_flush_reg;

`ifdef HSV_CORE_FLUSH_STATS_EN
    logic [FLUSH_STATS_W-1:0] stat_flushes_reg;
    logic [FLUSH_STATS_W-1:0] stat_flush_cycles_reg;

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            stat_flushes_reg      <= '0;
            stat_flush_cycles_reg <= '0;
        end else begin
            if (start_flush) begin
                stat_flushes_reg <= sat_inc(stat_flushes_reg);
            end
            if (state_reg != IDLE) begin
                stat_flush_cycles_reg <= sat_inc(stat_flush_cycles_reg);
            end
        end
    end

    assign stat_flushes      = stat_flushes_reg;
    assign stat_flush_cycles = stat_flush_cycles_reg;
`endif

endmodule

// File: tb/tb_hsv_core_flush_unit.sv
// Directed bench for hsv_core_flush_unit with a redirect scoreboard (define HSV_CORE_FLUSH_STATS_EN for stats).
module tb_hsv_core_flush_unit;

    localparam int NUM_STAGES = 4;

    logic                  clk_core = 1'b0;
    logic                  rst_core;
    logic [NUM_STAGES-1:0] stage_flush;
    logic [NUM_STAGES-1:0] stage_drained;
`ifdef HSV_CORE_FLUSH_STATS_EN
    logic [31:0]           stat_flushes;
    logic [31:0]           stat_flush_cycles;
`endif

    hsv_core_flush_unit_if fif();

    hsv_core_flush_unit #(
        .NUM_STAGES (NUM_STAGES)
    ) dut (
        .clk_core      (clk_core),
        .rst_core      (rst_core),
        .flush_if      (fif),
        .stage_flush   (stage_flush),
        .stage_drained (stage_drained)
`ifdef HSV_CORE_FLUSH_STATS_EN
        ,
        .stat_flushes      (stat_flushes),
        .stat_flush_cycles (stat_flush_cycles)
`endif
    );

    always #5 clk_core = ~clk_core;

    int checks_total  = 0;
    int checks_passed = 0;
    logic [31:0] exp_pc_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change and outputs are checked 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 20 && !fif.flush_ack; i++) tick();
        check(name, 32'(fif.flush_ack), 32'd1);
    endtask

    // Monitor: every accepted redirect must match the next expected PC.
    initial begin
        forever begin
            @(negedge clk_core);
            if (!rst_core && fif.fetch_redirect_valid && fif.fetch_redirect_ready) begin
                if (exp_pc_q.size() == 0) begin
                    checks_total++;
                    $display("FAIL unexpected_redirect: got pc 0x%08h, expected no redirect at %0t",
                             fif.fetch_redirect_pc, $time);
                end else begin
                    logic [31:0] exp_pc;
                    exp_pc = exp_pc_q.pop_front();
                    check("redirect_pc", fif.fetch_redirect_pc, exp_pc);
                    $display("redirect accepted pc=0x%08h expected=0x%08h", fif.fetch_redirect_pc, exp_pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

`ifdef HSV_CORE_FLUSH_STATS_EN
    // One complete flush lasting n non-IDLE cycles (n >= 3), drains and ready immediate.
    task automatic run_flush(input int n, input logic [31:0] pc);
        fif.flush_req = 1'b1; fif.flush_target = pc; stage_drained = '1; fif.fetch_redirect_ready = 1'b1;
        exp_pc_q.push_back(pc);
        tick();
        repeat (n - 1) tick();
        fif.flush_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst_core = 1'b1;
        fif.flush_req = 1'b0; fif.flush_target = '0; fif.fetch_redirect_ready = 1'b0;
        stage_drained = '0;
        tick(); tick();
        rst_core = 1'b0;
        tick();
        check("rst_ack", 32'(fif.flush_ack), 32'd0);
        check("rst_stage_flush", 32'(stage_flush), 32'd0);
        check("rst_valid", 32'(fif.fetch_redirect_valid), 32'd0);
        check("rst_pc", fif.fetch_redirect_pc, 32'd0);
        $display("txn reset done");

        // Basic handshake: minimum latency path.
        fif.flush_req = 1'b1; fif.fetch_redirect_ready = 1'b1;
        exp_pc_q.push_back(32'h0000_1000);
        tick();
        check("basic_stage_flush_e1", 32'(stage_flush), 32'hF);
        check("basic_valid_e1", 32'(fif.fetch_redirect_valid), 32'd0);
        fif.flush_target = 32'h0000_1000;
        tick();
        check("basic_valid_e2", 32'(fif.fetch_redirect_valid), 32'd0);
        stage_drained = 4'b1111;
        tick();
        check("basic_valid_e3", 32'(fif.fetch_redirect_valid), 32'd1);
        check("basic_pc_e3", fif.fetch_redirect_pc, 32'h0000_1000);
        check("basic_ack_e3", 32'(fif.flush_ack), 32'd0);
        stage_drained = '0;
        tick();
        check("basic_ack_e4", 32'(fif.flush_ack), 32'd1);
        check("basic_valid_e4", 32'(fif.fetch_redirect_valid), 32'd0);
        fif.flush_req = 1'b0;
        tick();
        check("basic_ack_drop", 32'(fif.flush_ack), 32'd0);
        check("basic_stage_flush_drop", 32'(stage_flush), 32'd0);
        $display("txn basic handshake done");

        // Staggered single-cycle drain pulses.
        fif.flush_req = 1'b1; fif.flush_target = 32'h0000_2000;
        exp_pc_q.push_back(32'h0000_2000);
        tick();
        stage_drained = 4'b0001; tick(); check("stag_valid_b0", 32'(fif.fetch_redirect_valid), 32'd0);
        stage_drained = 4'b0000; tick(); check("stag_valid_gap", 32'(fif.fetch_redirect_valid), 32'd0);
        stage_drained = 4'b0100; tick(); check("stag_valid_b2", 32'(fif.fetch_redirect_valid), 32'd0);
        stage_drained = 4'b0010; tick(); check("stag_valid_b1", 32'(fif.fetch_redirect_valid), 32'd0);
        stage_drained = 4'b1000; tick(); check("stag_valid_b3", 32'(fif.fetch_redirect_valid), 32'd1);
        check("stag_pc", fif.fetch_redirect_pc, 32'h0000_2000);
        stage_drained = 4'b0000;
        wait_ack("stag_ack");
        fif.flush_req = 1'b0;
        tick();
        check("stag_ack_drop", 32'(fif.flush_ack), 32'd0);
        $display("txn staggered drains done");

        // Fetch backpressure for 5 cycles.
        fif.flush_req = 1'b1; fif.flush_target = 32'h8000_0040;
        fif.fetch_redirect_ready = 1'b0; stage_drained = 4'b1111;
        exp_pc_q.push_back(32'h8000_0040);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(fif.fetch_redirect_valid), 32'd1);
            check("bp_pc", fif.fetch_redirect_pc, 32'h8000_0040);
            check("bp_ack", 32'(fif.flush_ack), 32'd0);
            tick();
        end
        fif.fetch_redirect_ready = 1'b1;
        check("bp_valid_ready", 32'(fif.fetch_redirect_valid), 32'd1);
        check("bp_ack_ready", 32'(fif.flush_ack), 32'd0);
        tick();
        check("bp_ack_after", 32'(fif.flush_ack), 32'd1);
        check("bp_valid_after", 32'(fif.fetch_redirect_valid), 32'd0);
        fif.flush_req = 1'b0;
        tick();
        $display("txn backpressure done");

        // Long hold in ACK: no second redirect, outputs held.
        fif.flush_req = 1'b1; fif.flush_target = 32'h0000_3000;
        exp_pc_q.push_back(32'h0000_3000);
        tick();
        wait_ack("hold_ack");
        for (int i = 0; i < 100; i++) begin
            check("hold_ack_level", 32'(fif.flush_ack), 32'd1);
            check("hold_stage_flush", 32'(stage_flush), 32'hF);
            tick();
        end
        fif.flush_req = 1'b0;
        tick();
        check("hold_ack_drop", 32'(fif.flush_ack), 32'd0);
        $display("txn ack hold done");

        // Reset while the redirect is pending.
        fif.flush_req = 1'b1; fif.flush_target = 32'h0000_4000; fif.fetch_redirect_ready = 1'b0;
        tick(); tick();
        check("rmid_valid_before", 32'(fif.fetch_redirect_valid), 32'd1);
        rst_core = 1'b1;
        tick();
        check("rmid_valid", 32'(fif.fetch_redirect_valid), 32'd0);
        check("rmid_ack", 32'(fif.flush_ack), 32'd0);
        check("rmid_stage_flush", 32'(stage_flush), 32'd0);
        check("rmid_pc", fif.fetch_redirect_pc, 32'd0);
        rst_core = 1'b0; fif.flush_req = 1'b0;
        tick();
        fif.flush_req = 1'b1; fif.flush_target = 32'h0000_5000; fif.fetch_redirect_ready = 1'b1;
        exp_pc_q.push_back(32'h0000_5000);
        tick();
        wait_ack("rmid_new_ack");
        fif.flush_req = 1'b0;
        tick();
        check("rmid_new_drop", 32'(stage_flush), 32'd0);
        $display("txn reset mid-sequence done");

`ifdef HSV_CORE_FLUSH_STATS_EN
        rst_core = 1'b1; tick(); rst_core = 1'b0; tick();
        run_flush(6, 32'h0000_6000);
        run_flush(9, 32'h0000_7000);
        check("stat_flushes", stat_flushes, 32'd2);
        check("stat_flush_cycles", stat_flush_cycles, 32'd15);
        force dut.stat_flushes_reg = 32'hFFFF_FFFF;
        force dut.stat_flush_cycles_reg = 32'hFFFF_FFFF;
        tick();
        release dut.stat_flushes_reg;
        release dut.stat_flush_cycles_reg;
        run_flush(4, 32'h0000_8000);
        check("stat_flushes_sat", stat_flushes, 32'hFFFF_FFFF);
        check("stat_cycles_sat", stat_flush_cycles, 32'hFFFF_FFFF);
        $display("txn stats done");
`endif

        stage_drained = '0;
        tick(); tick();
        check("scoreboard_empty", 32'(exp_pc_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/hsv_core_flush_unit.md
Name: hsv_core_flush_unit

Overview:
- Sits directly downstream of the control/status FSM. It consumes that FSM's `flush_req`/`flush_target` four-phase request and returns `flush_ack`.
- On a request it broadcasts a flush to all `NUM_STAGES` pipeline stages and waits until every stage reports drained.
- It then redirects fetch to the captured target with a valid/ready handshake, and acknowledges the FSM.
- It releases the stages only after the FSM withdraws `flush_req`.

Parameters:
- `NUM_STAGES`, 4, number of flushable pipeline stages (1..16).

Ports:
- `clk_core`  in  1  core clock; all logic is on its rising edge.
- `rst_core`  in  1  synchronous, active-high reset.
- `flush_req`  in  1  flush request from the ctrlstatus FSM (level).
- `flush_target`  in  32 (`word`)  restart PC from the ctrlstatus FSM.
- `flush_ack`  out  1  flush complete; held while `flush_req` is high.
- `stage_flush`  out  `NUM_STAGES`  per-stage flush command (level).
- `stage_drained`  in  `NUM_STAGES`  per-stage drained indication; a level or a single-cycle pulse is accepted.
- `fetch_redirect_valid`  out  1  redirect request to fetch.
- `fetch_redirect_pc`  out  32  redirect address.
- `fetch_redirect_ready`  in  1  fetch accepts the redirect.

Behaviour:
- Reset values: `state`=IDLE, `flush_ack`=0, `stage_flush`=0, `fetch_redirect_valid`=0, `fetch_redirect_pc`=0, drained mask=0.
- Reset asserted mid-operation abandons the sequence: all outputs return to reset values on the next edge, and no redirect is issued.
- All outputs are registered.
- States are IDLE, DRAIN, REDIRECT, ACK.
- IDLE:
  - When `flush_req`=1, go to DRAIN at the next edge.
  - On that edge set `stage_flush` to all-ones and clear the drained mask.
- DRAIN:
  - Each cycle, mask |= `stage_drained`. Bits are sticky, so a pulse seen in any DRAIN cycle counts.
  - When (mask | `stage_drained`) is all-ones, capture `flush_target` into `fetch_redirect_pc`, set `fetch_redirect_valid`=1, and go to REDIRECT.
  - `flush_target` is sampled at DRAIN exit, never at IDLE exit. The upstream FSM updates `flush_target` one cycle after first raising `flush_req`, and DRAIN lasts at least one cycle.
- REDIRECT:
  - Hold `fetch_redirect_valid` and `fetch_redirect_pc` stable until `fetch_redirect_ready`=1.
  - On that cycle's edge clear `fetch_redirect_valid`, set `flush_ack`=1, and go to ACK.
- ACK:
  - `stage_flush` stays all-ones and `flush_ack` stays 1 while `flush_req`=1. This covers an unbounded hold, e.g. upstream waiting for an IRQ.
  - When `flush_req`=0, clear `flush_ack` and `stage_flush` on the same edge and go to IDLE.
- Latency:
  - Minimum `flush_req`-high to `flush_ack`-high is 3 edges: IDLE→DRAIN, drained seen, ready seen.
  - `flush_req` low to `flush_ack` low is 1 edge.
- If `flush_req` drops before ACK, this is a protocol violation. The sequence still completes through REDIRECT; in ACK it sees `flush_req`=0 and returns to IDLE. This guarantees exactly one redirect per entered sequence.
- `flush_req`=1 in the same cycle as the ACK→IDLE transition is impossible by construction, because the exit requires `flush_req`=0.
- In IDLE, `stage_drained` is ignored.
- `fetch_redirect_pc` retains its last value when not valid.

Optional Feature:
- Macro: `HSV_CORE_FLUSH_STATS_EN`.
- When defined, adds two outputs, each reset to 0 and saturating at all-ones (no wrap):
  - `stat_flushes` (out, 32): increments on each IDLE→DRAIN.
  - `stat_flush_cycles` (out, 32): increments every cycle `state`≠IDLE.
- When undefined, neither port nor its counter exists, and behaviour is otherwise identical.

Decomposition:
- `hsv_core_pkg` supplies `word`.
- A new package `hsv_core_flush_pkg` holds `flush_state_t` (enum IDLE, DRAIN, REDIRECT, ACK) and `FLUSH_STATS_W`=32.
- Sub-module `hsv_core_flush_drain_collector`:
  - Ports: clk, rst, clear, `stage_drained[NUM_STAGES]`.
  - Keeps the sticky mask and outputs `all_drained` (combinational OR with the current input).

Test Plan:
- Basic handshake:
  - Stimulus: `NUM_STAGES`=4; `flush_req` rises at cycle 0; `flush_target`=0x0000_1000 from cycle 1; `stage_drained`=4'b1111 at cycle 2; `fetch_redirect_ready`=1.
  - Required response: `stage_flush`=4'hF at edge 1; `fetch_redirect_pc`=0x1000 and valid at edge 3; `flush_ack`=1 at edge 4; dropping `flush_req` gives `flush_ack`=0 and `stage_flush`=0 one edge later.
- Staggered pulsed drains:
  - Stimulus: single-cycle pulses on bits 0, 2, 1, 3 in separate cycles.
  - Required response: no redirect until the cycle bit 3 pulses; exactly one redirect.
- Fetch backpressure:
  - Stimulus: `fetch_redirect_ready`=0 for 5 cycles.
  - Required response: valid and PC (0x8000_0040) stable for all 5 cycles; `flush_ack` stays 0 until the edge after ready.
- Hold in ACK:
  - Stimulus: `flush_req` held high 100 cycles after ack.
  - Required response: `flush_ack`=1 and `stage_flush`=4'hF throughout; no second redirect.
- Reset mid-sequence:
  - Stimulus: assert `rst_core` during REDIRECT.
  - Required response: next edge has valid=0, `flush_ack`=0, `stage_flush`=0, `state`=IDLE; a new request then completes normally.
- Stats (with `HSV_CORE_FLUSH_STATS_EN`):
  - Stimulus: two back-to-back flushes of 6 and 9 non-IDLE cycles.
  - Required response: `stat_flushes`=2, `stat_flush_cycles`=15; preset counters to 0xFFFF_FFFF and confirm they hold.
